// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between an interconnect/master and the SRAM slave.
// The master modport drives address/control/write data; the slave returns status.
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        output HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        input  HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave over a register-array memory with programmable wait states,
// byte-lane writes and two-cycle ERROR responses for illegal accesses.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [63:0] BYTES = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  rdy_q;
    logic                  resp_q;
    logic                  load;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic          acc;
    logic          mis;
    logic          illegal;
    logic [LB-1:0] off;
    logic [IW-1:0] idx;
    logic [NB-1:0] be;

    assign acc = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign off = addr_q[LB-1:0];
    assign idx = addr_q[LB +: IW];

    always_comb begin
        mis = 1'b0;
        case (bus.HSIZE)
            3'd1:    mis = bus.HADDR[0];
            3'd2:    mis = |bus.HADDR[1:0];
            3'd3:    mis = |bus.HADDR[2:0];
            default: mis = 1'b0;
        endcase
        illegal = (64'(bus.HADDR) >= BYTES)
                | (bus.HSIZE > 3'(LB))
                | mis;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else cnt_d = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all open a new address phase
                if (acc) begin
                    load = 1'b1;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdy_q   <= 1'b1;
            resp_q  <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= !(state_d inside {S_WAIT, S_ERR1});
            resp_q  <= state_d inside {S_ERR1, S_ERR2};
            if (load) begin
                addr_q  <= bus.HADDR;
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
        end
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off)) &&
                    (b < int'(off) + (1 << size_q));
        end
    end

    // Array is never reset; a beat cut short by reset writes nothing
    always_ff @(posedge HCLK) begin
        if (HRESETn && state_q == S_DATA && write_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    assign bus.HRDATA    = (state_q == S_DATA) ? mem_q[idx] : '0;
    assign bus.HREADYOUT = rdy_q;
    assign bus.HRESP     = resp_q;

    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0], addr_q};
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed scoreboard bench: one slave with two wait states, one with none,
// selected by sel0 and sharing a single bus master.
module tb_ahb_lite_sram_slave;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_lite_sram_slave_if b2 ();
    ahb_lite_sram_slave_if b0 ();

    ahb_lite_sram_slave #(.WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(b2.slave)
    );
    ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(b0.slave)
    );

    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = '0;
    logic        sel0 = 1'b0;

    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    assign rdy   = sel0 ? b0.HREADYOUT : b2.HREADYOUT;
    assign resp  = sel0 ? b0.HRESP : b2.HRESP;
    assign rdata = sel0 ? b0.HRDATA : b2.HRDATA;

    assign b2.HSEL = hsel & ~sel0;
    assign b0.HSEL = hsel & sel0;
    assign b2.HADDR = haddr;
    assign b0.HADDR = haddr;
    assign b2.HWDATA = hwdata;
    assign b0.HWDATA = hwdata;
    assign b2.HWRITE = hwrite;
    assign b0.HWRITE = hwrite;
    assign b2.HSIZE = hsize;
    assign b0.HSIZE = hsize;
    assign b2.HBURST = 3'd0;
    assign b0.HBURST = 3'd0;
    assign b2.HPROT = 4'b0011;
    assign b0.HPROT = 4'b0011;
    assign b2.HTRANS = htrans;
    assign b0.HTRANS = htrans;
    assign b2.HREADY = rdy;
    assign b0.HREADY = rdy;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input bit w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] wd,
                        input bit err, input logic [31:0] rd);
        exp_t e;
        int waits;
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = s;
        e.err   = err;
        e.rdata = err ? 32'h0 : rd;
        e.waits = err ? 1 : (sel0 ? 0 : 2);
        sb.push_back(e);
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
        waits = 0;
        while (rdy !== 1'b1 && waits < 20) begin
            check({tag, "_resp_lo"}, 32'(resp), 32'(err));
            @(negedge HCLK);
            waits++;
        end
        e = sb.pop_front();
        check({tag, "_waits"}, 32'(waits), 32'(e.waits));
        check({tag, "_resp"}, 32'(resp), 32'(e.err));
        if (!w) check({tag, "_rdata"}, rdata, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // reset and idle outputs
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_rdy2", 32'(b2.HREADYOUT), 32'd1);
        check("rst_resp2", 32'(b2.HRESP), 32'd0);
        check("rst_rdata2", b2.HRDATA, 32'h0);
        check("rst_rdy0", 32'(b0.HREADYOUT), 32'd1);
        check("rst_resp0", 32'(b0.HRESP), 32'd0);
        check("rst_rdata0", b0.HRDATA, 32'h0);

        // word write/read with two wait states
        xfer("t2_w", 1, 32'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0);
        xfer("t2_r", 0, 32'h010, 3'd2, 32'h0, 0, 32'hDEADBEEF);

        // sub-word lane writes
        xfer("t3_wb", 1, 32'h013, 3'd0, 32'h55000000, 0, 32'h0);
        xfer("t3_rb", 0, 32'h010, 3'd2, 32'h0, 0, 32'h55ADBEEF);
        xfer("t3_wh", 1, 32'h012, 3'd1, 32'h12340000, 0, 32'h0);
        xfer("t3_rh", 0, 32'h010, 3'd2, 32'h0, 0, 32'h1234BEEF);

        // illegal accesses leave memory intact
        xfer("t4_oor", 0, 32'h400, 3'd2, 32'h0, 1, 32'h0);
        xfer("t4_mis", 1, 32'h011, 3'd1, 32'hFFFFFFFF, 1, 32'h0);
        xfer("t4_dw", 1, 32'h010, 3'd3, 32'hFFFFFFFF, 1, 32'h0);
        xfer("t4_rd", 0, 32'h010, 3'd2, 32'h0, 0, 32'h1234BEEF);

        // last word in range; byte read drives all lanes
        xfer("bnd_w", 1, 32'h3FC, 3'd2, 32'hCAFEF00D, 0, 32'h0);
        xfer("bnd_r", 0, 32'h3FD, 3'd0, 32'h0, 0, 32'hCAFEF00D);

        // zero-wait back-to-back write then read
        sel0 = 1'b1;
        xfer("t5_pre", 1, 32'h020, 3'd2, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        haddr = 32'h020; hsize = 3'd2;
        @(negedge HCLK);
        check("t5_w_rdy", 32'(rdy), 32'd1);
        check("t5_w_resp", 32'(resp), 32'd0);
        hwdata = 32'hA5A5A5A5; hwrite = 1'b0;
        e.err = 0; e.rdata = 32'hA5A5A5A5; e.waits = 0;
        sb.push_back(e);
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00;
        e = sb.pop_front();
        check("t5_r_rdy", 32'(rdy), 32'd1);
        check("t5_r_resp", 32'(resp), 32'(e.err));
        check("t5_r_rdata", rdata, e.rdata);
        sel0 = 1'b0;

        // reset during a write wait state drops the write
        xfer("t6_old", 1, 32'h030, 3'd2, 32'h11112222, 0, 32'h0);
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        haddr = 32'h030; hsize = 3'd2;
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hwdata = 32'hFFFF0000;
        check("t6_wait_rdy", 32'(rdy), 32'd0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        check("t6_rst_rdy", 32'(rdy), 32'd1);
        check("t6_rst_resp", 32'(resp), 32'd0);
        check("t6_rst_rdata", rdata, 32'h0);
        repeat (3) @(negedge HCLK);
        check("t6_idle_rdy", 32'(rdy), 32'd1);
        xfer("t6_r", 0, 32'h030, 3'd2, 32'h0, 0, 32'h11112222);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
